// File: rtl/sinc3.sv
`default_nettype none
// ============================================================================
// Module   : sinc3
// Brief    : Third-order sinc (CIC) decimator for a 1-bit delta-sigma stream,
//            producing a 16-bit full-scale-normalized result and a strobe.
// Revision : 1.0 - initial release
// ============================================================================
module sinc3 #(
    parameter int ACC_W = 25
) (
    input  logic        MCLK,
    input  logic        RST,
    input  logic        MDAT,
    input  logic [1:0]  MODE,
    output logic [15:0] SNCOUT,
    output logic        ENBL
);

    localparam int         CNT_W       = 8;
    localparam int         SCL_W       = ACC_W + 1;
    localparam logic [1:0] SETTLE_DONE = 2'd3;

    logic [1:0]       mode_q;
    logic             mode_change;
    logic             clear;

    logic [ACC_W-1:0] integ1;
    logic [ACC_W-1:0] integ2;
    logic [ACC_W-1:0] integ3;

    logic [CNT_W-1:0] frame_cnt;
    logic [CNT_W-1:0] frame_last;
    logic             frame_end;

    logic [ACC_W-1:0] dly1;
    logic [ACC_W-1:0] dly2;
    logic [ACC_W-1:0] dly3;
    logic [ACC_W-1:0] comb1;
    logic [ACC_W-1:0] comb2;
    logic [ACC_W-1:0] comb3;
    logic [ACC_W-1:0] comb_out;

    logic [1:0]       settle_cnt;
    logic             out_pending;

    logic [SCL_W-1:0] widened;
    logic [SCL_W-1:0] scaled;
    logic [15:0]      result;

    // A MODE change restarts the filter exactly like reset, but keeps SNCOUT.
    assign mode_change = (MODE != mode_q);
    assign clear       = !RST || mode_change;

    always_comb begin
        frame_last = 8'd255;
        case (mode_q)
            2'd0:    frame_last = 8'd31;
            2'd1:    frame_last = 8'd63;
            2'd2:    frame_last = 8'd127;
            default: frame_last = 8'd255;
        endcase
    end

    assign frame_end = (frame_cnt == frame_last);

    // Modulo differences; integrator wrap-around cancels out here.
    assign comb1 = integ3 - dly1;
    assign comb2 = comb1 - dly2;
    assign comb3 = comb2 - dly3;

    // Normalize R^3 full scale to 2^16, then clip the all-ones case.
    assign widened = {1'b0, comb_out};

    always_comb begin
        scaled = widened >> 8;
        case (mode_q)
            2'd0:    scaled = widened << 1;
            2'd1:    scaled = widened >> 2;
            2'd2:    scaled = widened >> 5;
            default: scaled = widened >> 8;
        endcase
    end

    assign result = (|scaled[SCL_W-1:16]) ? 16'hFFFF : scaled[15:0];

    always_ff @(posedge MCLK) begin
        if (clear) begin
            mode_q      <= MODE;
            integ1      <= '0;
            integ2      <= '0;
            integ3      <= '0;
            frame_cnt   <= '0;
            dly1        <= '0;
            dly2        <= '0;
            dly3        <= '0;
            comb_out    <= '0;
            settle_cnt  <= '0;
            out_pending <= 1'b0;
            ENBL        <= 1'b0;
            if (!RST) begin
                SNCOUT <= '0;
            end
        end else begin
            integ1 <= integ1 + {{(ACC_W-1){1'b0}}, MDAT};
            integ2 <= integ2 + integ1;
            integ3 <= integ3 + integ2;

            ENBL        <= out_pending;
            out_pending <= 1'b0;
            if (out_pending) begin
                SNCOUT <= result;
            end

            if (frame_end) begin
                frame_cnt <= '0;
                dly1      <= integ3;
                dly2      <= comb1;
                dly3      <= comb2;
                comb_out  <= comb3;
                // The first three frames only fill the comb history.
                if (settle_cnt == SETTLE_DONE) begin
                    out_pending <= 1'b1;
                end else begin
                    settle_cnt <= settle_cnt + 2'd1;
                end
            end else begin
                frame_cnt <= frame_cnt + CNT_W'(1);
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_sinc3.sv
`default_nettype none
// ============================================================================
// Module   : tb_sinc3
// Brief    : Self-checking bench for sinc3: DC-pattern vector table plus
//            mode-switch and mid-frame reset sequences.
// Revision : 1.0 - initial release
// ============================================================================
module tb_sinc3;

    logic        MCLK = 1'b0;
    logic        RST  = 1'b0;
    logic        MDAT = 1'b0;
    logic [1:0]  MODE = 2'd3;
    logic [15:0] SNCOUT;
    logic        ENBL;

    sinc3 #(.ACC_W(25)) dut (
        .MCLK   (MCLK),
        .RST    (RST),
        .MDAT   (MDAT),
        .MODE   (MODE),
        .SNCOUT (SNCOUT),
        .ENBL   (ENBL)
    );

    always #5 MCLK = ~MCLK;

    typedef struct {
        logic [1:0]  mode;
        logic [7:0]  pat;
        int          len;
        logic [15:0] expv;
        string       name;
    } vec_t;

    vec_t        vecs[10];
    int          n_checks = 0;
    int          n_fail   = 0;
    int          cyc      = 0;
    int          exp_next = 0;
    int          period   = 32;
    logic [7:0]  pat      = 8'h00;
    int          plen     = 1;
    int          pidx     = 0;
    logic [15:0] sb[$];

    task automatic check16(input string nm, input logic [15:0] act, input logic [15:0] req);
        n_checks++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h (cycle %0d)", nm, act, req, cyc);
        end
    endtask

    task automatic check_int(input string nm, input int act, input int req);
        n_checks++;
        if (act != req) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d (cycle %0d)", nm, act, req, cyc);
        end
    endtask

    // One cycle: sample at the falling edge, then drive the next bit.
    task automatic step();
        logic [15:0] e;
        @(negedge MCLK);
        cyc++;
        if (ENBL === 1'b1) begin
            check_int("enbl_time", cyc, exp_next);
            if (cyc == exp_next) exp_next += period;
            if (sb.size() == 0) begin
                check_int("sb_depth", sb.size(), 1);
            end else begin
                e = sb.pop_front();
                check16("sncout", SNCOUT, e);
            end
        end else if (cyc == exp_next) begin
            check16("enbl_missing", {15'd0, ENBL}, 16'd1);
            exp_next += period;
            if (sb.size() != 0) e = sb.pop_front();
        end
        MDAT = pat[pidx];
        pidx = (pidx + 1) % plen;
    endtask

    task automatic run_to(input int end_cyc, input logic [15:0] val);
        for (int t = exp_next; t <= end_cyc; t += period) sb.push_back(val);
        while (cyc < end_cyc) step();
        check_int("sb_empty", sb.size(), 0);
    endtask

    // Called at a falling edge; applies one reset edge, checks, releases.
    task automatic do_reset(input logic [1:0] m);
        RST  = 1'b0;
        MODE = m;
        MDAT = 1'b0;
        @(negedge MCLK);
        check16("reset_sncout", SNCOUT, 16'h0000);
        check16("reset_enbl", {15'd0, ENBL}, 16'd0);
        RST      = 1'b1;
        cyc      = 0;
        period   = 32 << m;
        exp_next = 4 * period + 1;
        sb.delete();
        pidx     = 0;
        MDAT     = pat[0];
        pidx     = 1 % plen;
    endtask

    initial begin
        vecs[0] = '{2'd3, 8'h00, 1, 16'h0000, "m3_zero"};
        vecs[1] = '{2'd3, 8'h01, 1, 16'hFFFF, "m3_ones"};
        vecs[2] = '{2'd3, 8'h01, 2, 16'h8000, "m3_alt"};
        vecs[3] = '{2'd0, 8'h01, 2, 16'h8000, "m0_alt"};
        vecs[4] = '{2'd1, 8'h01, 2, 16'h8000, "m1_alt"};
        vecs[5] = '{2'd2, 8'h01, 2, 16'h8000, "m2_alt"};
        vecs[6] = '{2'd3, 8'h07, 4, 16'hC000, "m3_75pct"};
        vecs[7] = '{2'd0, 8'h01, 1, 16'hFFFF, "m0_ones"};
        vecs[8] = '{2'd0, 8'h07, 4, 16'hC000, "m0_75pct"};
        vecs[9] = '{2'd1, 8'h01, 4, 16'h4000, "m1_25pct"};

        @(negedge MCLK);
        for (int v = 0; v < 10; v++) begin
            pat  = vecs[v].pat;
            plen = vecs[v].len;
            do_reset(vecs[v].mode);
            run_to(6 * period + 5, vecs[v].expv);
            check16({vecs[v].name, "_hold"}, SNCOUT, vecs[v].expv);
        end

        // MODE 3 -> 0 mid-frame: output holds, then re-settles at R=32.
        pat  = 8'h01;
        plen = 2;
        do_reset(2'd3);
        run_to(1381, 16'h8000);
        check16("pre_switch_hold", SNCOUT, 16'h8000);
        pat      = 8'h07;
        plen     = 4;
        pidx     = 0;
        MODE     = 2'd0;
        period   = 32;
        exp_next = 1382 + 4 * 32 + 1;
        run_to(1500, 16'hC000);
        check16("switch_hold", SNCOUT, 16'h8000);
        run_to(1580, 16'hC000);

        // Mid-frame reset, then reset on the cycle a strobe was due.
        pat  = 8'h01;
        plen = 2;
        do_reset(2'd1);
        run_to(405, 16'h8000);
        do_reset(2'd1);
        run_to(320, 16'h8000);
        do_reset(2'd1);
        run_to(4 * 64 + 6, 16'h8000);
        check16("final_value", SNCOUT, 16'h8000);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
